// File: rtl/ps2_pkg.sv
// Shared constants and decoder state for the PS/2 keyboard-to-hex block.
package ps2_pkg;

  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef struct packed {
    logic brk;
    logic ext;
  } dec_state_t;

  // start=0, stop=1, odd parity over the data byte plus parity bit
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return !f[0] && f[PS2_FRAME_BITS-1] && (^f[PS2_FRAME_BITS-2:1]);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchroniser, falling-edge detect, shift register, frame check.
// Optional idle timeout that discards partial frames is enabled by PS2KBD_TIMEOUT_EN.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  // Synchronisers reset to the idle-high line level so reset never fakes an edge
  logic [2:0] clk_sync_reg;
  logic [1:0] data_sync_reg;
  logic [3:0] bit_cnt_reg;
  // First ten bits of the frame; the eleventh is combined directly from the pin
  logic [PS2_FRAME_BITS-2:0] shift_reg;
  logic [PS2_FRAME_BITS-1:0] frame_next;
  logic fall;
  logic data_bit;

  assign fall       = clk_sync_reg[2] & ~clk_sync_reg[1];
  assign data_bit   = data_sync_reg[1];
  assign frame_next = {data_bit, shift_reg};

`ifdef PS2KBD_TIMEOUT_EN
  logic [31:0] idle_cnt_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_reg  <= 3'b111;
      data_sync_reg <= 2'b11;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      rx_byte       <= '0;
      rx_valid      <= 1'b0;
      rx_err        <= 1'b0;
`ifdef PS2KBD_TIMEOUT_EN
      idle_cnt_reg  <= '0;
`endif
    end else begin
      clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      rx_valid      <= 1'b0;
      rx_err        <= 1'b0;
      if (fall) begin
        if (bit_cnt_reg == 4'(PS2_FRAME_BITS - 1)) begin
          bit_cnt_reg <= '0;
          shift_reg   <= '0;
          rx_byte     <= frame_next[8:1];
          rx_valid    <= frame_ok(frame_next);
          rx_err      <= !frame_ok(frame_next);
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
          shift_reg   <= {data_bit, shift_reg[PS2_FRAME_BITS-2:1]};
        end
      end
`ifdef PS2KBD_TIMEOUT_EN
      if (fall) begin
        idle_cnt_reg <= '0;
      end else if (idle_cnt_reg != 32'(TIMEOUT_CYCLES - 1)) begin
        idle_cnt_reg <= idle_cnt_reg + 32'd1;
      end
      if (!fall && bit_cnt_reg != 4'd0 && idle_cnt_reg == 32'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
        rx_err      <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/ps2_kbd_hex.sv
// PS/2 keyboard front end: receiver, show-ahead scancode FIFO and make/break decoder.
// Build with PS2KBD_TIMEOUT_EN to discard stalled partial frames after TIMEOUT_CYCLES.
module ps2_kbd_hex
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] o_code,
  output logic [7:0] o_count,
  output logic       o_held,
  output logic       o_ext,
  output logic       o_err,
  output logic       o_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  assign o_err = rx_err;

  // Pointers carry one wrap bit so full and empty are distinguishable
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_reg;
  logic [PTR_W:0] rd_ptr_reg;
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;
  logic [7:0]     pop_byte;
  dec_state_t     dec_reg;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg == {~rd_ptr_reg[PTR_W], rd_ptr_reg[PTR_W-1:0]});
  assign pop      = !empty;
  assign push     = rx_valid && (!full || pop);
  assign pop_byte = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      o_ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (rx_valid && full && !pop) o_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_reg <= '0;
      o_code  <= '0;
      o_count <= '0;
      o_held  <= 1'b0;
      o_ext   <= 1'b0;
    end else if (pop) begin
      if (pop_byte == PS2_EXT) begin
        dec_reg.ext <= 1'b1;
      end else if (pop_byte == PS2_BRK) begin
        dec_reg.brk <= 1'b1;
      end else if (dec_reg.brk) begin
        if (pop_byte == o_code) o_held <= 1'b0;
        dec_reg <= '0;
      end else begin
        // Typematic repeats of the held key leave everything untouched
        if (!o_held || pop_byte != o_code) begin
          o_code  <= pop_byte;
          o_ext   <= dec_reg.ext;
          o_held  <= 1'b1;
          o_count <= o_count + 8'd1;
        end
        dec_reg.ext <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_hex.sv
// Self-checking bench for ps2_kbd_hex: PS/2 frames driven on the pins, outputs checked
// against a keyboard-level model of make/break/typematic behaviour.
module tb_ps2_kbd_hex;

  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 200;
  localparam int H          = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] o_code;
  logic [7:0] o_count;
  logic       o_held;
  logic       o_ext;
  logic       o_err;
  logic       o_ovf;

  ps2_kbd_hex #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .o_code  (o_code),
    .o_count (o_count),
    .o_held  (o_held),
    .o_ext   (o_ext),
    .o_err   (o_err),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int err_hi  = 0;

  always @(negedge clk) if (o_err === 1'b1) err_hi++;

  // Keyboard-level model
  logic [7:0] m_code, m_count;
  logic       m_held, m_ext, m_brk, m_extf;

  function automatic void model_reset();
    m_code = 8'h00; m_count = 8'h00; m_held = 1'b0; m_ext = 1'b0;
    m_brk = 1'b0; m_extf = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_extf = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin
      if (b == m_code) m_held = 1'b0;
      m_brk = 1'b0; m_extf = 1'b0;
    end else begin
      if (!m_held || b != m_code) begin
        m_code = b; m_ext = m_extf; m_held = 1'b1; m_count = m_count + 8'd1;
      end
      m_extf = 1'b0;
    end
  endfunction

  task automatic drive_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(bits[i]);
    repeat (8) @(negedge clk);
    if (!bad_par) model_byte(b);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({o_code, o_count, o_held, o_ext, o_err, o_ovf} !== 20'h0)
      $display("FAIL reset_outputs: got %h want 00000", {o_code, o_count, o_held, o_ext, o_err, o_ovf});
    else n_pass++;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    logic [10:0] bits;
    bits = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) drive_bit(bits[i]);
    @(negedge clk) ps2_data = bits[10];
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (o_count !== 8'h00) $display("FAIL latency_early: count %h want 00", o_count); else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({o_code, o_held, o_count, o_ext} !== {8'h1C, 1'b1, 8'h01, 1'b0})
      $display("FAIL latency_n3: code %h held %b count %h ext %b want 1c 1 01 0", o_code, o_held, o_count, o_ext);
    else n_pass++;
    @(negedge clk) ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
    model_byte(8'h1C);
  endtask

  task automatic test_release();
    do_reset();
    send_frame(8'h1C, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h1C, 1'b0);
    n_total++;
    if ({o_held, o_code, o_count} !== {1'b0, 8'h1C, 8'h01})
      $display("FAIL release: held %b code %h count %h want 0 1c 01", o_held, o_code, o_count);
    else n_pass++;
    send_frame(8'h32, 1'b0);
    n_total++;
    if ({o_held, o_code, o_count} !== {1'b1, 8'h32, 8'h02})
      $display("FAIL press_after_release: held %b code %h count %h want 1 32 02", o_held, o_code, o_count);
    else n_pass++;
  endtask

  task automatic test_typematic();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h1C, 1'b0);
      n_total++;
      if ({o_code, o_count, o_held} !== {8'h1C, 8'h01, 1'b1})
        $display("FAIL typematic_%0d: code %h count %h held %b want 1c 01 1", i, o_code, o_count, o_held);
      else n_pass++;
    end
    send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
    n_total++;
    if ({o_code, o_ext, o_count} !== {8'h75, 1'b1, 8'h02})
      $display("FAIL extended: code %h ext %b count %h want 75 1 02", o_code, o_ext, o_count);
    else n_pass++;
  endtask

  task automatic test_bad_parity();
    int e0;
    e0 = err_hi;
    send_frame(8'h1C, 1'b1);
    n_total++;
    if (err_hi - e0 != 1) $display("FAIL bad_parity_err_cycles: got %0d want 1", err_hi - e0); else n_pass++;
    n_total++;
    if ({o_code, o_count} !== {m_code, m_count})
      $display("FAIL bad_parity_unchanged: code %h count %h want %h %h", o_code, o_count, m_code, m_count);
    else n_pass++;
    send_frame(8'h1C, 1'b0);
    n_total++;
    if ({o_code, o_count, o_held} !== {8'h1C, m_count, 1'b1} || m_code != 8'h1C)
      $display("FAIL after_bad_frame: code %h count %h held %b want 1c %h 1", o_code, o_count, o_held, m_count);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] pool [5];
    logic [7:0] b;
    int e0;
    pool[0] = 8'h1C; pool[1] = 8'h32; pool[2] = 8'h29; pool[3] = 8'h75; pool[4] = 8'h00;
    e0 = err_hi;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1, 2:    b = 8'hF0;
        3:       b = 8'($urandom_range(1, 8'hDF));
        default: b = pool[$urandom_range(0, 3)];
      endcase
      send_frame(b, 1'b0);
      n_total++;
      if ({o_code, o_count, o_held, o_ext} !== {m_code, m_count, m_held, m_ext})
        $display("FAIL random_%0d byte %h: code %h count %h held %b ext %b want %h %h %b %b",
                 i, b, o_code, o_count, o_held, o_ext, m_code, m_count, m_held, m_ext);
      else n_pass++;
    end
    n_total++;
    if (err_hi != e0) $display("FAIL random_no_err: err cycles %0d want 0", err_hi - e0); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    do_reset();
    send_frame(8'h1C, 1'b0);
    n_total++;
    if ({o_code, o_count, o_held} !== {8'h1C, 8'h01, 1'b1})
      $display("FAIL reset_midframe: code %h count %h held %b want 1c 01 1", o_code, o_count, o_held);
    else n_pass++;
  endtask

`ifdef PS2KBD_TIMEOUT_EN
  task automatic test_timeout();
    int e0;
    do_reset();
    e0 = err_hi;
    for (int i = 0; i < 5; i++) drive_bit(1'b0);
    repeat (TIMEOUT + 10) @(negedge clk);
    n_total++;
    if (err_hi - e0 != 1) $display("FAIL timeout_err: got %0d cycles want 1", err_hi - e0); else n_pass++;
    send_frame(8'h1C, 1'b0);
    n_total++;
    if ({o_code, o_count} !== {8'h1C, 8'h01})
      $display("FAIL timeout_recover: code %h count %h want 1c 01", o_code, o_count);
    else n_pass++;
  endtask
`endif

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_frame(8'h29, 1'b0);
      if (i == 254) begin
        n_total++;
        if (o_count !== 8'hFF) $display("FAIL wrap_ff: count %h want ff", o_count); else n_pass++;
      end
      send_frame(8'hF0, 1'b0); send_frame(8'h29, 1'b0);
    end
    n_total++;
    if ({o_count, o_held} !== {8'h00, 1'b0} || m_count != 8'h00)
      $display("FAIL wrap_00: count %h held %b want 00 0", o_count, o_held);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    force dut.pop = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0);
    n_total++;
    if ({o_ovf, o_count} !== {1'b0, 8'h00})
      $display("FAIL fifo_full_no_ovf: ovf %b count %h want 0 00", o_ovf, o_count);
    else n_pass++;
    send_frame(8'h40, 1'b0);
    n_total++;
    if (o_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", o_ovf); else n_pass++;
    release dut.pop;
    repeat (20) @(negedge clk);
    n_total++;
    if ({o_ovf, o_count, o_code} !== {1'b1, 8'(FIFO_DEPTH), 8'h10 + 8'(FIFO_DEPTH - 1)})
      $display("FAIL ovf_drain: ovf %b count %h code %h want 1 %h %h", o_ovf, o_count, o_code,
               8'(FIFO_DEPTH), 8'h10 + 8'(FIFO_DEPTH - 1));
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({o_ovf, o_count} !== {1'b0, 8'h00}) $display("FAIL ovf_cleared: ovf %b count %h want 0 00", o_ovf, o_count);
    else n_pass++;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_release();
    test_typematic();
    test_bad_parity();
    test_random();
    test_reset_midframe();
`ifdef PS2KBD_TIMEOUT_EN
    test_timeout();
`endif
    test_wrap();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_hex.md
# ps2_kbd_hex

Receives PS/2 keyboard frames and turns them into a registered scancode, a key-held flag and a press counter. It sits directly upstream of the board's seven-segment display driver, which renders the hex nibbles of `o_code` and `o_count`. The block contains three stages: a PS/2 frame receiver, a small scancode FIFO, and a make/break decoder.

## Interface
- `FIFO_DEPTH`, default 8: scancode FIFO entries; must be a power of two, ≥ 2.
- `TIMEOUT_CYCLES`, default 50000: idle `clk` cycles before a partial frame is discarded (used only with the macro).
- `clk` in 1: system clock. Board PS/2 clock is 10–16.7 kHz, so `clk` must be ≥ 1 MHz.
- `rst` in 1: reset, asynchronous and active-low. `rst`=0 resets the block; release is taken on `clk`.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `o_code` out 8: last make scancode, excluding the `E0` and `F0` prefixes.
- `o_count` out 8: number of distinct key presses, binary, wraps.
- `o_held` out 1: the key in `o_code` is currently pressed.
- `o_ext` out 1: the last make code had an `E0` prefix.
- `o_err` out 1: one-cycle pulse on a frame error.
- `o_ovf` out 1: sticky FIFO overflow flag; cleared only by reset.

## Operation
- **Synchroniser.** `ps2_clk` and `ps2_data` each pass through 2 flip-flops. A third flip-flop on the clock path detects a falling edge: previous value 1, current value 0.
- **Receiver.** A 4-bit bit counter and an 11-bit shift register, LSB first, sample data on each detected falling edge.
  - The frame is start (0), 8 data bits, odd parity, stop (1).
  - On the 11th bit, the frame is valid when start=0, stop=1 and XOR(data, parity)=1.
  - A valid frame pushes its data byte into the FIFO.
  - An invalid frame is dropped and raises `o_err` for 1 cycle.
  - The bit counter returns to 0 after 11 bits, whether the frame was valid or not.
- **FIFO.** Show-ahead, depth `FIFO_DEPTH`.
  - A push while full is dropped and sets `o_ovf`, unless a pop occurs in the same cycle; then the push is accepted.
  - On a simultaneous push and pop, occupancy is unchanged.
- **Decoder.** Pops one byte per cycle whenever the FIFO is not empty, and keeps two flags: `brk` and `ext`.
  - Byte `E0`: set `ext`.
  - Byte `F0`: set `brk`.
  - Other byte `b` with `brk`=1 (release): if `b`==`o_code`, clear `o_held`; otherwise no output change. Then clear `brk` and `ext`.
  - Other byte `b` with `brk`=0 (make): if `o_held`=0 or `b`≠`o_code`, load `o_code`←`b`, `o_ext`←`ext`, `o_held`←1 and `o_count`←`o_count`+1. Typematic repeats (same code while held) change nothing. Then clear `ext`.
- **Counter wrap.** `o_count` is 8-bit and wraps from `FF` to `00`.
- **Reset values.** All outputs are 0, the FIFO is empty, and the bit counter and flags are 0. Reset asserted mid-frame discards the partial frame.
  - Without the macro, a frame that is partial when reset is released stays misaligned until it produces an error frame. This is accepted behaviour.

## Timing
- Pin to detected edge takes 3 `clk` cycles (synchroniser plus edge flip-flop).
- Let N be the cycle in which the 11th edge is detected.
  - N+1: byte is in the FIFO and `o_err` is pulsed if the frame is bad.
  - N+2: decoder pops the byte.
  - N+3: `o_code`, `o_held`, `o_count` and `o_ext` show the new values.
- All outputs are registered. There are no combinational paths from pins to outputs.

## Configuration
- `PS2KBD_TIMEOUT_EN` defined:
  - A counter restarts on every detected edge.
  - If the bit counter is non-zero and `TIMEOUT_CYCLES` elapse with no edge, the bit counter and shift register clear and `o_err` pulses for 1 cycle.
- Undefined: no timeout logic; the receiver waits indefinitely for the next edge.

## Structure
- Package `ps2_pkg` holds these constants:
  - `PS2_BRK` = 8'hF0 and `PS2_EXT` = 8'hE0.
  - `PS2_FRAME_BITS` = 11.
  - The decoder state struct: `brk`, `ext`.
- One sub-module, `ps2_rx`: synchroniser, edge detect, shift register, frame check and the optional timeout. Its outputs are `rx_byte`, `rx_valid` and `rx_err`.
- The FIFO and the decoder stay in the top module.

## Test plan
- Frame `1C` (bits 0,00111000,0,1) → at N+3: `o_code`=1C, `o_held`=1, `o_count`=01, `o_ext`=0.
- `1C`, `F0`, `1C` → `o_held`=0, `o_code`=1C, `o_count`=01. Then `32` → `o_code`=32, `o_count`=02.
- `1C` sent 4 times without release (typematic) → `o_count` stays 01. Then `E0 75` → `o_code`=75, `o_ext`=1, `o_count`=02.
- Frame `1C` with parity 1 → `o_err` high for exactly 1 cycle; `o_code` and `o_count` unchanged. The next good frame decodes normally.
- 256 press/release pairs of `29` → `o_count`=00. With the decoder stalled by force and `FIFO_DEPTH`+1 frames sent → `o_ovf`=1, held until `rst`=0.
- With `PS2KBD_TIMEOUT_EN`: 5 bits, then idle for `TIMEOUT_CYCLES`+1 → `o_err` pulses. A following full `1C` frame decodes to `o_code`=1C.
